dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_lane_align.sv | 45 ++++
 rtl/dmem_responder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings,
// FSM states and the byte-lane width.
package dmem_pkg;

  localparam int BYTE_W = 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte-enables, lane-replicated store
// data and sign/zero-extended load data for one 32-bit word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rext
);

  logic [BYTE_W-1:0]   byte_sel;
  logic [2*BYTE_W-1:0] half_sel;

  // Store data is replicated into every lane; the byte-enables pick the one written.
  always_comb begin
    byte_sel = rword[offset*BYTE_W +: BYTE_W];
    half_sel = offset[1] ? rword[31:16] : rword[15:0];
    be       = 4'b1111;
    wlane    = wdata;
    rext     = rword;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << offset;
        wlane = {4{wdata[7:0]}};
        rext  = is_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be    = offset[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata[15:0]}};
        rext  = is_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        be    = 4'b1111;
        wlane = wdata;
        rext  = rword;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory responder with a configurable access latency.
// Define DMEM_ERR_CHECK_EN to flag misaligned, out-of-range and reserved-size requests.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state;
  logic [3:0]  cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        enter_resp;
  logic        mem_we;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [1:0]  acc_size;
  logic        acc_unsigned;
  logic [31:0] acc_wdata;
  logic [29:0] word_idx;
  logic [IDX_W-1:0] idx;
  logic [1:0]  eff_size;
  logic [1:0]  eff_off;
  logic        err;
  logic [3:0]  be;
  logic [31:0] wlane;
  logic [31:0] rext;
  logic [31:0] load_data;

  // With no wait cycles the access happens on the accept edge, so it must use the live request.
  always_comb begin
    accept       = req_valid && req_ready;
    enter_resp   = (state == ST_IDLE && accept && NO_WAIT) || (state == ST_WAIT && cnt == 4'd0);
    acc_we       = (state == ST_IDLE) ? req_we       : r_we;
    acc_addr     = (state == ST_IDLE) ? req_addr     : r_addr;
    acc_size     = (state == ST_IDLE) ? req_size     : r_size;
    acc_unsigned = (state == ST_IDLE) ? req_unsigned : r_unsigned;
    acc_wdata    = (state == ST_IDLE) ? req_wdata    : r_wdata;
    word_idx     = acc_addr[31:2];
    idx          = IDX_W'(word_idx % 30'(DEPTH_WORDS));
  end

  always_comb begin
    eff_size = acc_size;
    eff_off  = acc_addr[1:0];
    err      = 1'b0;
`ifdef DMEM_ERR_CHECK_EN
    if ((acc_size == SZ_HALF && acc_addr[0]) ||
        (acc_size == SZ_WORD && acc_addr[1:0] != 2'b00) ||
        (acc_size == SZ_RSVD) ||
        (word_idx >= 30'(DEPTH_WORDS)))
      err = 1'b1;
`else
    if (acc_size == SZ_RSVD) eff_size = SZ_WORD;
    if (eff_size == SZ_HALF) eff_off = {acc_addr[1], 1'b0};
    else if (eff_size == SZ_WORD) eff_off = 2'b00;
`endif
  end

  dmem_lane_align u_align (
    .size        (eff_size),
    .offset      (eff_off),
    .is_unsigned (acc_unsigned),
    .wdata       (acc_wdata),
    .rword       (mem[idx]),
    .be          (be),
    .wlane       (wlane),
    .rext        (rext)
  );

  assign load_data = (err || acc_we) ? 32'd0 : rext;
  assign mem_we    = reset && enter_resp && acc_we && !err;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][b*BYTE_W +: BYTE_W] <= wlane[b*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'd0;
      rsp_err    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 32'd0;
      r_size     <= SZ_BYTE;
      r_unsigned <= 1'b0;
      r_wdata    <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            r_we       <= req_we;
            r_addr     <= req_addr;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_wdata    <= req_wdata;
            req_ready  <= 1'b0;
            if (NO_WAIT) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= load_data;
              rsp_err   <= err;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= load_data;
            rsp_err   <= err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
